crc_stream_gen: RTL and testbench
=================================

Name: crc_stream_gen

Overview:
- Parametrised streaming CRC engine, successor to the byte-serial CRC-32 block.
- Processes DATA_BYTES bytes per beat with configurable polynomial, init, reflection and output XOR.
- Uses framed input (sof/eof/keep) and a valid/ready result handshake, and reports frame length and residue check.
- Sits between the packet assembler (TX FCS generation) and the RX path (FCS check) of the ARP packet generator.

Parameters:
- DATA_BYTES, 4: bytes per input beat; legal values 1, 2, 4, 8.
- CRC_W, 32: CRC width in bits; legal range 8..32.
- POLY, 32'h04C11DB7: generator polynomial, normal (MSB-first) form, low CRC_W bits used.
- INIT, 32'hFFFFFFFF: register value at frame start.
- REFLECT_IN, 1: 1 = each byte processed LSB first.
- REFLECT_OUT, 1: 1 = final register bit-reversed over CRC_W before the XOR.
- XOR_OUT, 32'hFFFFFFFF: XORed onto the output value.
- RESIDUE, 32'hC704DD7B: raw register value indicating a good frame when the FCS is included.
- LEN_W, 16: width of the frame byte counter.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- clr, in, 1: synchronous clear, highest priority.
- s_valid, in, 1: input beat valid.
- s_ready, out, 1: engine can accept a beat.
- s_data, in, 8*DATA_BYTES: beat data; byte lane 0 ([7:0]) is processed first.
- s_keep, in, DATA_BYTES: byte enables, contiguous from lane 0; used only on eof beats.
- s_sof, in, 1: first beat of frame.
- s_eof, in, 1: last beat of frame.
- m_valid, out, 1: result valid.
- m_ready, in, 1: result accepted.
- m_crc, out, CRC_W: final CRC (after reflect-out and XOR_OUT).
- m_len, out, LEN_W: frame length in bytes; saturates at all-ones.
- m_check_ok, out, 1: raw register equals RESIDUE[CRC_W-1:0] at eof.

Behaviour:
- Reset (async) and clr (sync) produce the same state:
  - state IDLE, register = INIT, byte count = 0.
  - s_ready = 1; m_valid = 0; m_crc = 0; m_len = 0; m_check_ok = 0.
  - clr overrides any beat or handshake in the same cycle; a beat presented with clr is discarded.
- A beat is accepted when s_valid && s_ready.
- States:
  - IDLE: no frame open.
  - ACC: frame open.
  - HOLD: result presented; s_ready = 0.
  - s_ready = 1 in IDLE and ACC.
- Accepted beat with s_sof, or any accepted beat in IDLE: the register is reloaded with INIT before folding, and the count restarts from 0. A sof in ACC discards the partial frame silently.
- Folding:
  - Lanes are processed in order 0..N-1, all within one cycle.
  - Each byte is bit-reversed if REFLECT_IN, then XORed into the register's top 8 bits, then shifted 8 times MSB-first, XORing POLY when the bit shifted out is 1.
  - Non-eof beats fold all DATA_BYTES lanes; keep is ignored.
  - eof beats fold only lanes with keep = 1. keep = 0 on eof folds nothing and finalizes the frame as is.
- Count:
  - Adds the number of folded bytes per beat; saturates at 2^LEN_W-1.
- Non-eof beat: next state ACC.
- eof beat:
  - Next state HOLD.
  - On the same edge, the following are registered:
    - m_crc = (REFLECT_OUT ? bitrev(reg_new) : reg_new) ^ XOR_OUT.
    - m_len = final count.
    - m_check_ok = (reg_new == RESIDUE).
  - m_valid rises the cycle after the eof beat is accepted (latency 1).
- sof and eof on the same beat: single-beat frame, INIT load plus fold plus finalize.
- HOLD:
  - m_valid, m_crc, m_len and m_check_ok remain stable until m_ready.
  - On m_valid && m_ready: next state IDLE, m_valid = 0 next cycle, s_ready = 1 next cycle. m_crc, m_len and m_check_ok keep their values.
  - No beat is accepted in the handshake cycle.
- Only the low CRC_W bits of POLY, INIT, XOR_OUT and RESIDUE are used. When CRC_W < 8, the top-aligned XOR is undefined; this is illegal by the parameter range.

Test Plan:
1. Default params, DATA_BYTES=1, ASCII "123456789" (0x31..0x39, sof on first, eof on last): m_crc = 0xCBF43926, m_len = 9, m_check_ok = 0; m_valid high 1 cycle after the eof beat.
2. DATA_BYTES=4, same string as beats 0x34333231 / 0x38373635 / 0x00000039 with keep 1111 / 1111 / 0001 on eof: m_crc = 0xCBF43926, m_len = 9. Then send the 13-byte stream with FCS bytes 26 39 F4 CB appended: m_check_ok = 1, m_len = 13.
3. REFLECT_IN=0, REFLECT_OUT=0, XOR_OUT=0 (CRC-32/MPEG-2), "123456789": m_crc = 0x0376E6E7.
4. Backpressure: hold m_ready = 0 for 5 cycles after the result appears. s_ready = 0 throughout; m_valid, m_crc and m_len are stable; a s_valid beat offered meanwhile is not consumed. Raise m_ready: m_valid = 0 and s_ready = 1 on the next cycle.
5. Restart and clear:
   - sof beat mid-frame: result equals that of the new frame only.
   - clr pulse mid-frame: next frame "123456789" gives 0xCBF43926.
   - eof beat with keep = 0 after 4 bytes "1234": m_len = 4, m_crc = 0x9BE3E0A3.
6. Reset: assert rst_n low during HOLD, asynchronously, mid-cycle. Outputs drop to the reset values immediately, with s_ready = 1.

Source files
------------

// File: rtl/crc_stream_gen_if.sv
// Framed beat input plus valid/ready result channel of crc_stream_gen.
//   s_valid/s_ready : beat handshake
//   s_data          : beat data, byte lane 0 ([7:0]) processed first
//   s_keep          : byte enables (eof beats only), contiguous from lane 0
//   s_sof/s_eof     : frame delimiters
//   m_valid/m_ready : result handshake
//   m_crc           : final CRC after reflect-out and output XOR
//   m_len           : frame length in bytes, saturating
//   m_check_ok      : raw register matched the residue at eof
// master = producer/consumer side (bench, packet path); slave = engine.
interface crc_stream_gen_if #(
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned CRC_W      = 32,
  parameter int unsigned LEN_W      = 16
);
  logic                    s_valid;
  logic                    s_ready;
  logic [8*DATA_BYTES-1:0] s_data;
  logic [DATA_BYTES-1:0]   s_keep;
  logic                    s_sof;
  logic                    s_eof;
  logic                    m_valid;
  logic                    m_ready;
  logic [CRC_W-1:0]        m_crc;
  logic [LEN_W-1:0]        m_len;
  logic                    m_check_ok;

  modport master (
    output s_valid, s_data, s_keep, s_sof, s_eof, m_ready,
    input  s_ready, m_valid, m_crc, m_len, m_check_ok
  );

  modport slave (
    input  s_valid, s_data, s_keep, s_sof, s_eof, m_ready,
    output s_ready, m_valid, m_crc, m_len, m_check_ok
  );
endinterface

// File: rtl/crc_stream_gen.sv
// Parametrised streaming CRC engine: folds DATA_BYTES bytes per beat into a
// CRC_W-bit register, finalizes on eof and holds the result until accepted.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear, overrides any beat or handshake
//   bus   : crc_stream_gen_if slave (beat input, result output)
module crc_stream_gen #(
  parameter int unsigned DATA_BYTES  = 4,
  parameter int unsigned CRC_W       = 32,
  parameter logic [31:0] POLY        = 32'h04C11DB7,
  parameter logic [31:0] INIT        = 32'hFFFFFFFF,
  parameter bit          REFLECT_IN  = 1'b1,
  parameter bit          REFLECT_OUT = 1'b1,
  parameter logic [31:0] XOR_OUT     = 32'hFFFFFFFF,
  parameter logic [31:0] RESIDUE     = 32'hC704DD7B,
  parameter int unsigned LEN_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  crc_stream_gen_if.slave   bus
);

  localparam logic [CRC_W-1:0] POLY_C = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] INIT_C = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] XOR_C  = XOR_OUT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] RES_C  = RESIDUE[CRC_W-1:0];

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_HOLD} state_e;

  state_e           state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [CRC_W-1:0] m_crc_q, m_crc_d;
  logic [LEN_W-1:0] m_len_q, m_len_d;
  logic             m_ok_q, m_ok_d;

  logic             s_ready_int;
  logic             accept;
  logic             start;
  logic [CRC_W-1:0] fold_crc;
  logic [LEN_W-1:0] base_cnt;
  logic [LEN_W:0]   nbytes;
  logic [LEN_W:0]   cnt_sum;
  logic [LEN_W-1:0] cnt_new;

  // One byte, MSB-first shift register form; reflected input is handled by
  // reversing the byte before it enters the top of the register.
  function automatic logic [CRC_W-1:0] fold_byte(input logic [CRC_W-1:0] c_in,
                                                 input logic [7:0] b);
    logic [CRC_W-1:0] c;
    logic [7:0]       d;
    for (int unsigned i = 0; i < 8; i++) begin
      d[i] = REFLECT_IN ? b[7-i] : b[i];
    end
    c = c_in;
    c[CRC_W-1 -: 8] = c[CRC_W-1 -: 8] ^ d;
    for (int unsigned k = 0; k < 8; k++) begin
      c = c[CRC_W-1] ? ((c << 1) ^ POLY_C) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [CRC_W-1:0] bitrev_crc(input logic [CRC_W-1:0] c);
    logic [CRC_W-1:0] r;
    for (int unsigned i = 0; i < CRC_W; i++) begin
      r[i] = c[CRC_W-1-i];
    end
    return r;
  endfunction

  assign s_ready_int = (state_q != S_HOLD);
  assign accept      = bus.s_valid && s_ready_int;

  // Fold path: evaluated every cycle, only committed on an accepted beat.
  always_comb begin
    start    = bus.s_sof || (state_q == S_IDLE);
    fold_crc = start ? INIT_C : crc_q;
    base_cnt = start ? '0 : cnt_q;
    nbytes   = '0;
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      if (!bus.s_eof || bus.s_keep[i]) begin
        fold_crc = fold_byte(fold_crc, bus.s_data[8*i +: 8]);
        nbytes   = nbytes + (LEN_W+1)'(1);
      end
    end
    cnt_sum = {1'b0, base_cnt} + nbytes;
    cnt_new = cnt_sum[LEN_W] ? '1 : cnt_sum[LEN_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    m_crc_d = m_crc_q;
    m_len_d = m_len_q;
    m_ok_d  = m_ok_q;
    if (clr) begin
      state_d = S_IDLE;
      crc_d   = INIT_C;
      cnt_d   = '0;
      m_crc_d = '0;
      m_len_d = '0;
      m_ok_d  = 1'b0;
    end else if (accept) begin
      crc_d = fold_crc;
      cnt_d = cnt_new;
      if (bus.s_eof) begin
        state_d = S_HOLD;
        m_crc_d = (REFLECT_OUT ? bitrev_crc(fold_crc) : fold_crc) ^ XOR_C;
        m_len_d = cnt_new;
        m_ok_d  = (fold_crc == RES_C);
      end else begin
        state_d = S_ACC;
      end
    end else if (state_q == S_HOLD && bus.m_ready) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      crc_q   <= INIT_C;
      cnt_q   <= '0;
      m_crc_q <= '0;
      m_len_q <= '0;
      m_ok_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      m_crc_q <= m_crc_d;
      m_len_q <= m_len_d;
      m_ok_q  <= m_ok_d;
    end
  end

  assign bus.s_ready    = s_ready_int;
  assign bus.m_valid    = (state_q == S_HOLD);
  assign bus.m_crc      = m_crc_q;
  assign bus.m_len      = m_len_q;
  assign bus.m_check_ok = m_ok_q;

endmodule

// File: tb/tb_crc_stream_gen.sv
// Directed bench for crc_stream_gen: three instances (1-byte CRC-32, 4-byte
// CRC-32, 1-byte CRC-32/MPEG-2) checked against known reference CRC values.
module tb_crc_stream_gen;

  logic clk;
  logic rst_n;
  logic clr;

  int n_checks;
  int n_fail;

  crc_stream_gen_if #(.DATA_BYTES(1), .CRC_W(32), .LEN_W(16)) if1 ();
  crc_stream_gen_if #(.DATA_BYTES(4), .CRC_W(32), .LEN_W(16)) if4 ();
  crc_stream_gen_if #(.DATA_BYTES(1), .CRC_W(32), .LEN_W(16)) ifm ();

  crc_stream_gen #(.DATA_BYTES(1)) u_b1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if1)
  );

  crc_stream_gen #(.DATA_BYTES(4)) u_b4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if4)
  );

  crc_stream_gen #(
    .DATA_BYTES(1), .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0), .XOR_OUT(32'h0)
  ) u_mpeg (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(ifm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  // One byte beat, driven identically into the 1-byte CRC-32 and MPEG-2 units.
  task automatic send1(input logic [7:0] d, input logic sof, input logic eof);
    @(negedge clk);
    if1.s_valid = 1'b1; if1.s_data = d; if1.s_keep = 1'b1;
    if1.s_sof = sof;    if1.s_eof = eof;
    ifm.s_valid = 1'b1; ifm.s_data = d; ifm.s_keep = 1'b1;
    ifm.s_sof = sof;    ifm.s_eof = eof;
    @(posedge clk); #1;
    if1.s_valid = 1'b0; if1.s_sof = 1'b0; if1.s_eof = 1'b0;
    ifm.s_valid = 1'b0; ifm.s_sof = 1'b0; ifm.s_eof = 1'b0;
  endtask

  // Sends the first n characters of "123456789" as one frame.
  task automatic send_digits(input int n);
    for (int i = 0; i < n; i++) begin
      send1(8'(8'h31 + i), i == 0, i == n - 1);
    end
  endtask

  task automatic ack1;
    @(negedge clk);
    if1.m_ready = 1'b1; ifm.m_ready = 1'b1;
    @(posedge clk); #1;
    if1.m_ready = 1'b0; ifm.m_ready = 1'b0;
  endtask

  task automatic send4(input logic [31:0] d, input logic [3:0] keep,
                       input logic sof, input logic eof);
    @(negedge clk);
    if4.s_valid = 1'b1; if4.s_data = d; if4.s_keep = keep;
    if4.s_sof = sof;    if4.s_eof = eof;
    @(posedge clk); #1;
    if4.s_valid = 1'b0; if4.s_sof = 1'b0; if4.s_eof = 1'b0;
  endtask

  task automatic ack4;
    @(negedge clk);
    if4.m_ready = 1'b1;
    @(posedge clk); #1;
    if4.m_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (if1.s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready got %b expected 1", if1.s_ready); end
    n_checks++; if (if1.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b expected 0", if1.m_valid); end
    n_checks++; if (if4.m_crc !== 32'h0) begin n_fail++; $display("FAIL reset_m_crc got %h expected 00000000", if4.m_crc); end
    n_checks++; if (if4.m_len !== 16'h0) begin n_fail++; $display("FAIL reset_m_len got %0d expected 0", if4.m_len); end
    n_checks++; if (if4.m_check_ok !== 1'b0) begin n_fail++; $display("FAIL reset_check_ok got %b expected 0", if4.m_check_ok); end
    rst_n = 1'b1;
  endtask

  task automatic test_crc32_bytes;
    for (int i = 0; i < 8; i++) send1(8'(8'h31 + i), i == 0, 1'b0);
    n_checks++; if (if1.m_valid !== 1'b0) begin n_fail++; $display("FAIL crc32_early_valid got %b expected 0", if1.m_valid); end
    send1(8'h39, 1'b0, 1'b1);
    n_checks++; if (if1.m_valid !== 1'b1) begin n_fail++; $display("FAIL crc32_latency got m_valid %b expected 1", if1.m_valid); end
    n_checks++; if (if1.m_crc !== 32'hCBF43926) begin n_fail++; $display("FAIL crc32_crc got %h expected cbf43926", if1.m_crc); end
    n_checks++; if (if1.m_len !== 16'd9) begin n_fail++; $display("FAIL crc32_len got %0d expected 9", if1.m_len); end
    n_checks++; if (if1.m_check_ok !== 1'b0) begin n_fail++; $display("FAIL crc32_check_ok got %b expected 0", if1.m_check_ok); end
    n_checks++; if (if1.s_ready !== 1'b0) begin n_fail++; $display("FAIL crc32_hold_ready got %b expected 0", if1.s_ready); end
    ack1;
  endtask

  task automatic test_mpeg2;
    send_digits(9);
    n_checks++; if (ifm.m_crc !== 32'h0376E6E7) begin n_fail++; $display("FAIL mpeg2_crc got %h expected 0376e6e7", ifm.m_crc); end
    n_checks++; if (ifm.m_len !== 16'd9) begin n_fail++; $display("FAIL mpeg2_len got %0d expected 9", ifm.m_len); end
    ack1;
  endtask

  task automatic test_backpressure;
    send_digits(4);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if1.s_valid = 1'b1; if1.s_data = 8'h41; if1.s_keep = 1'b1;
      if1.s_sof = 1'b1;   if1.s_eof = 1'b1;
      ifm.s_valid = 1'b1; ifm.s_data = 8'h41; ifm.s_keep = 1'b1;
      ifm.s_sof = 1'b1;   ifm.s_eof = 1'b1;
      n_checks++; if (if1.s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_s_ready cycle %0d got %b expected 0", c, if1.s_ready); end
      n_checks++; if (if1.m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_m_valid cycle %0d got %b expected 1", c, if1.m_valid); end
      n_checks++; if (if1.m_crc !== 32'h9BE3E0A3) begin n_fail++; $display("FAIL bp_m_crc cycle %0d got %h expected 9be3e0a3", c, if1.m_crc); end
      n_checks++; if (if1.m_len !== 16'd4) begin n_fail++; $display("FAIL bp_m_len cycle %0d got %0d expected 4", c, if1.m_len); end
    end
    @(negedge clk);
    if1.s_valid = 1'b0; if1.s_sof = 1'b0; if1.s_eof = 1'b0;
    ifm.s_valid = 1'b0; ifm.s_sof = 1'b0; ifm.s_eof = 1'b0;
    if1.m_ready = 1'b1; ifm.m_ready = 1'b1;
    @(posedge clk); #1;
    if1.m_ready = 1'b0; ifm.m_ready = 1'b0;
    n_checks++; if (if1.m_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b expected 0", if1.m_valid); end
    n_checks++; if (if1.s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b expected 1", if1.s_ready); end
    n_checks++; if (if1.m_crc !== 32'h9BE3E0A3) begin n_fail++; $display("FAIL bp_crc_kept got %h expected 9be3e0a3", if1.m_crc); end
    n_checks++; if (if1.m_len !== 16'd4) begin n_fail++; $display("FAIL bp_len_kept got %0d expected 4", if1.m_len); end
  endtask

  task automatic test_restart_clear;
    // Partial frame "ab" abandoned by a new sof.
    send1(8'h61, 1'b1, 1'b0);
    send1(8'h62, 1'b0, 1'b0);
    send_digits(9);
    n_checks++; if (if1.m_crc !== 32'hCBF43926) begin n_fail++; $display("FAIL restart_crc got %h expected cbf43926", if1.m_crc); end
    n_checks++; if (if1.m_len !== 16'd9) begin n_fail++; $display("FAIL restart_len got %0d expected 9", if1.m_len); end
    ack1;
    // Partial frame "12", then clr together with an eof beat that must be dropped.
    send1(8'h31, 1'b1, 1'b0);
    send1(8'h32, 1'b0, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    if1.s_valid = 1'b1; if1.s_data = 8'h33; if1.s_eof = 1'b1;
    ifm.s_valid = 1'b1; ifm.s_data = 8'h33; ifm.s_eof = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    if1.s_valid = 1'b0; if1.s_eof = 1'b0;
    ifm.s_valid = 1'b0; ifm.s_eof = 1'b0;
    n_checks++; if (if1.m_valid !== 1'b0) begin n_fail++; $display("FAIL clr_m_valid got %b expected 0", if1.m_valid); end
    n_checks++; if (if1.m_crc !== 32'h0) begin n_fail++; $display("FAIL clr_m_crc got %h expected 00000000", if1.m_crc); end
    n_checks++; if (if1.m_len !== 16'd0) begin n_fail++; $display("FAIL clr_m_len got %0d expected 0", if1.m_len); end
    n_checks++; if (if1.s_ready !== 1'b1) begin n_fail++; $display("FAIL clr_s_ready got %b expected 1", if1.s_ready); end
    send_digits(9);
    n_checks++; if (if1.m_crc !== 32'hCBF43926) begin n_fail++; $display("FAIL after_clr_crc got %h expected cbf43926", if1.m_crc); end
    n_checks++; if (if1.m_len !== 16'd9) begin n_fail++; $display("FAIL after_clr_len got %0d expected 9", if1.m_len); end
    ack1;
  endtask

  task automatic test_wide_beats;
    send4(32'h34333231, 4'hF, 1'b1, 1'b0);
    send4(32'h38373635, 4'hF, 1'b0, 1'b0);
    n_checks++; if (if4.m_valid !== 1'b0) begin n_fail++; $display("FAIL wide_early_valid got %b expected 0", if4.m_valid); end
    send4(32'h00000039, 4'b0001, 1'b0, 1'b1);
    n_checks++; if (if4.m_valid !== 1'b1) begin n_fail++; $display("FAIL wide_latency got m_valid %b expected 1", if4.m_valid); end
    n_checks++; if (if4.m_crc !== 32'hCBF43926) begin n_fail++; $display("FAIL wide_crc got %h expected cbf43926", if4.m_crc); end
    n_checks++; if (if4.m_len !== 16'd9) begin n_fail++; $display("FAIL wide_len got %0d expected 9", if4.m_len); end
    n_checks++; if (if4.m_check_ok !== 1'b0) begin n_fail++; $display("FAIL wide_check_ok got %b expected 0", if4.m_check_ok); end
    ack4;
    // Same string with its FCS appended: register lands on the residue.
    send4(32'h34333231, 4'hF, 1'b1, 1'b0);
    send4(32'h38373635, 4'hF, 1'b0, 1'b0);
    send4(32'hF4392639, 4'hF, 1'b0, 1'b0);
    send4(32'h000000CB, 4'b0001, 1'b0, 1'b1);
    n_checks++; if (if4.m_check_ok !== 1'b1) begin n_fail++; $display("FAIL fcs_check_ok got %b expected 1", if4.m_check_ok); end
    n_checks++; if (if4.m_len !== 16'd13) begin n_fail++; $display("FAIL fcs_len got %0d expected 13", if4.m_len); end
    n_checks++; if (if4.m_crc !== 32'h2144DF1C) begin n_fail++; $display("FAIL fcs_crc got %h expected 2144df1c", if4.m_crc); end
    ack4;
    // eof beat with no bytes kept closes the frame as it stands.
    send4(32'h34333231, 4'hF, 1'b1, 1'b0);
    send4(32'hDEADBEEF, 4'h0, 1'b0, 1'b1);
    n_checks++; if (if4.m_len !== 16'd4) begin n_fail++; $display("FAIL keep0_len got %0d expected 4", if4.m_len); end
    n_checks++; if (if4.m_crc !== 32'h9BE3E0A3) begin n_fail++; $display("FAIL keep0_crc got %h expected 9be3e0a3", if4.m_crc); end
    n_checks++; if (if4.s_ready !== 1'b0) begin n_fail++; $display("FAIL keep0_hold_ready got %b expected 0", if4.s_ready); end
    ack4;
    n_checks++; if (if4.s_ready !== 1'b1) begin n_fail++; $display("FAIL keep0_release_ready got %b expected 1", if4.s_ready); end
  endtask

  task automatic test_async_reset;
    send_digits(9);
    n_checks++; if (if1.m_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre_valid got %b expected 1", if1.m_valid); end
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (if1.m_valid !== 1'b0) begin n_fail++; $display("FAIL areset_m_valid got %b expected 0", if1.m_valid); end
    n_checks++; if (if1.s_ready !== 1'b1) begin n_fail++; $display("FAIL areset_s_ready got %b expected 1", if1.s_ready); end
    n_checks++; if (if1.m_crc !== 32'h0) begin n_fail++; $display("FAIL areset_m_crc got %h expected 00000000", if1.m_crc); end
    n_checks++; if (if1.m_len !== 16'd0) begin n_fail++; $display("FAIL areset_m_len got %0d expected 0", if1.m_len); end
    n_checks++; if (if1.m_check_ok !== 1'b0) begin n_fail++; $display("FAIL areset_check_ok got %b expected 0", if1.m_check_ok); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clr      = 1'b0;
    rst_n    = 1'b0;
    if1.s_valid = 1'b0; if1.s_data = '0; if1.s_keep = '0; if1.s_sof = 1'b0; if1.s_eof = 1'b0; if1.m_ready = 1'b0;
    if4.s_valid = 1'b0; if4.s_data = '0; if4.s_keep = '0; if4.s_sof = 1'b0; if4.s_eof = 1'b0; if4.m_ready = 1'b0;
    ifm.s_valid = 1'b0; ifm.s_data = '0; ifm.s_keep = '0; ifm.s_sof = 1'b0; ifm.s_eof = 1'b0; ifm.m_ready = 1'b0;

    test_reset;
    test_crc32_bytes;
    test_mpeg2;
    test_backpressure;
    test_restart_clear;
    test_wide_beats;
    test_async_reset;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
